ika2151_dac_serializer: RTL and testbench

Output-side parallel-to-serial converter for the OPM core, the counterpart of the noise SIPO. It takes the signed 16-bit left and right accumulator sums once per 32-slot frame. Each sum is converted to the 10-bit mantissa / 3-bit exponent floating-point word expected by the external YM3012-class DAC. Each word is shifted out LSB first on a single serial pin, with per-channel sample-hold strobes. It sits between the accumulator and the chip's SO/SH1/SH2 pins.

---
 rtl/ika2151_dac_serializer_pkg.sv | 32 +++
 rtl/ika2151_dac_serializer_if.sv | 32 +++
 rtl/ika2151_dac_serializer_fp_encoder.sv | 58 +++++
 rtl/ika2151_dac_serializer.sv | 92 +++++++++
 tb/tb_ika2151_dac_serializer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ika2151_dac_serializer_pkg.sv
// ika2151_pkg
// Shared constants and types for the OPM DAC output serializer.
//   FRAME_SLOTS / WORD_BITS / PAD_BITS / MANT_BITS / EXP_BITS : frame and word geometry
//   MANT_OFFSET : XOR mask that turns a two's-complement mantissa into offset binary
//   dac_word_t  : one DAC word, MSB first {expo, mant, pad}; shifted out LSB first
//   fits_mant() : true when a 16-bit value lies in the signed mantissa range [-512, 511]
package ika2151_pkg;

  localparam int FRAME_SLOTS = 32;
  localparam int WORD_BITS   = 16;
  localparam int PAD_BITS    = 3;
  localparam int MANT_BITS   = 10;
  localparam int EXP_BITS    = 3;
  localparam int SLOT_BITS   = $clog2(FRAME_SLOTS);

  localparam logic [MANT_BITS-1:0] MANT_OFFSET = 10'h200;

  typedef struct packed {
    logic [EXP_BITS-1:0]  expo;
    logic [MANT_BITS-1:0] mant;
    logic [PAD_BITS-1:0]  pad;
  } dac_word_t;

  // Biasing by +512 maps [-512, 511] onto [0, 1023]; anything else wraps
  // to 1024 or above, so one unsigned compare covers both bounds.
  function automatic logic fits_mant(input logic [WORD_BITS-1:0] v);
    logic [WORD_BITS-1:0] biased;
    biased = v + 16'd512;
    return biased < 16'd1024;
  endfunction

endpackage

// File: rtl/ika2151_dac_serializer_if.sv
// ika2151_dac_if
// Bundles the accumulator-side inputs and the DAC pin outputs of the serializer.
//   i_phi1_NCEN_n : active-low clock enable, state moves only on ticks where it is 0
//   i_CYCLE_31    : last slot of the frame, triggers the frame load
//   i_ACC_LD      : one-tick strobe marking i_ACC_L / i_ACC_R valid
//   i_ACC_L/R     : signed 16-bit channel sums
//   o_SO          : serial DAC data, LSB first
//   o_SH1 / o_SH2 : left / right sample-hold strobes
// Modports: master drives the inputs (accumulator side), slave is the serializer.
interface ika2151_dac_if;
  import ika2151_pkg::*;

  logic                        i_phi1_NCEN_n;
  logic                        i_CYCLE_31;
  logic                        i_ACC_LD;
  logic signed [WORD_BITS-1:0] i_ACC_L;
  logic signed [WORD_BITS-1:0] i_ACC_R;
  logic                        o_SO;
  logic                        o_SH1;
  logic                        o_SH2;

  modport master (
    output i_phi1_NCEN_n, i_CYCLE_31, i_ACC_LD, i_ACC_L, i_ACC_R,
    input  o_SO, o_SH1, o_SH2
  );

  modport slave (
    input  i_phi1_NCEN_n, i_CYCLE_31, i_ACC_LD, i_ACC_L, i_ACC_R,
    output o_SO, o_SH1, o_SH2
  );

endinterface

// File: rtl/ika2151_dac_serializer_fp_encoder.sv
// ika2151_fp_encoder
// Combinational conversion of a signed 16-bit sample into the DAC floating
// point word: exponent e in 1..7 is the smallest for which S>>>(e-1) fits a
// 10-bit signed mantissa; the mantissa is sent in offset binary.
//   s    : signed 16-bit sample
//   word : {e, mantissa ^ 0x200, 3'b000}
// Build option: IKA2151_DAC_ROUND_EN adds half-up rounding of the mantissa
// (default build truncates, which matches the original chip).
module ika2151_fp_encoder
  import ika2151_pkg::*;
(
  input  logic signed [WORD_BITS-1:0] s,
  output dac_word_t                   word
);

  logic [EXP_BITS-1:0]  exp_c;
  logic [MANT_BITS-1:0] shifted;
  logic [EXP_BITS-1:0]  exp_f;
  logic [MANT_BITS-1:0] mant_f;
`ifdef IKA2151_DAC_ROUND_EN
  logic                 rnd;
  logic [MANT_BITS:0]   sum;
`endif

  always_comb begin
    // Descending scan so the smallest fitting exponent is the last one kept.
    exp_c = 3'd7;
    for (int k = 7; k >= 1; k--) begin
      if (fits_mant(16'(s >>> (k - 1)))) exp_c = 3'(k);
    end
    shifted = 10'(s >>> (exp_c - 3'd1));
`ifdef IKA2151_DAC_ROUND_EN
    // The first bit shifted away decides the half-up rounding.
    rnd = (exp_c >= 3'd2) ? s[{1'b0, exp_c - 3'd2}] : 1'b0;
    sum = {shifted[MANT_BITS-1], shifted} + {10'd0, rnd};
    if (sum[MANT_BITS:MANT_BITS-1] == 2'b01) begin
      // Rounded up to +512: renormalise one exponent up, or saturate at the top.
      if (exp_c == 3'd7) begin
        exp_f  = exp_c;
        mant_f = 10'd511;
      end else begin
        exp_f  = exp_c + 3'd1;
        mant_f = 10'd256;
      end
    end else begin
      exp_f  = exp_c;
      mant_f = sum[MANT_BITS-1:0];
    end
`else
    exp_f  = exp_c;
    mant_f = shifted;
`endif
    word.expo = exp_f;
    word.mant = mant_f ^ MANT_OFFSET;
    word.pad  = '0;
  end

endmodule

// File: rtl/ika2151_dac_serializer.sv
// ika2151_dac_serializer
// Parallel-to-serial converter from the accumulator to the external DAC.
// Once per 32-slot frame both channel sums are encoded and loaded into a
// 32-bit shift register {word(R), word(L)}, then shifted out LSB first.
//   i_EMUCLK : master clock
//   i_MRST   : synchronous active-high reset (acts without a clock enable)
//   bus      : ika2151_dac_if.slave (enable, frame mark, sample load, DAC pins)
// Behaviour: SH1 is high for slots 0..15 (left word), SH2 for slots 16..31.
// All outputs stay 0 until the first frame load after reset.
// Build option: IKA2151_DAC_ROUND_EN selects rounding in the encoder.
module ika2151_dac_serializer
  import ika2151_pkg::*;
(
  input  logic         i_EMUCLK,
  input  logic         i_MRST,
  ika2151_dac_if.slave bus
);

  logic                        en;
  logic                        load;
  logic signed [WORD_BITS-1:0] hold_l;
  logic signed [WORD_BITS-1:0] hold_r;
  logic signed [WORD_BITS-1:0] src_l;
  logic signed [WORD_BITS-1:0] src_r;
  dac_word_t                   word_l;
  dac_word_t                   word_r;
  logic [2*WORD_BITS-1:0]      sr;
  logic [2*WORD_BITS-1:0]      sr_next;
  logic [SLOT_BITS-1:0]        slot;
  logic [SLOT_BITS-1:0]        slot_next;
  logic                        framed;
  logic                        framed_next;
  logic                        so_q;
  logic                        sh1_q;
  logic                        sh2_q;

  assign en   = ~bus.i_phi1_NCEN_n;
  assign load = en & bus.i_CYCLE_31;

  // A strobe on the load tick bypasses the hold registers so the new pair
  // goes out with one tick of latency instead of a whole frame.
  assign src_l = bus.i_ACC_LD ? bus.i_ACC_L : hold_l;
  assign src_r = bus.i_ACC_LD ? bus.i_ACC_R : hold_r;

  ika2151_fp_encoder u_enc_l (.s(src_l), .word(word_l));
  ika2151_fp_encoder u_enc_r (.s(src_r), .word(word_r));

  always_comb begin
    sr_next     = sr;
    slot_next   = slot;
    framed_next = framed;
    if (load) begin
      sr_next     = {word_r, word_l};
      slot_next   = '0;
      framed_next = 1'b1;
    end else if (en) begin
      sr_next   = {1'b0, sr[2*WORD_BITS-1:1]};
      slot_next = slot + 5'd1;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      sr     <= '0;
      slot   <= '0;
      framed <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      so_q   <= 1'b0;
      sh1_q  <= 1'b0;
      sh2_q  <= 1'b0;
    end else begin
      sr     <= sr_next;
      slot   <= slot_next;
      framed <= framed_next;
      if (en && bus.i_ACC_LD) begin
        hold_l <= bus.i_ACC_L;
        hold_r <= bus.i_ACC_R;
      end
      // Outputs are registered from the next-state values so they change on
      // the same edge as the slot they describe.
      so_q  <= framed_next & sr_next[0];
      sh1_q <= framed_next & ~slot_next[SLOT_BITS-1];
      sh2_q <= framed_next &  slot_next[SLOT_BITS-1];
    end
  end

  assign bus.o_SO  = so_q;
  assign bus.o_SH1 = sh1_q;
  assign bus.o_SH2 = sh2_q;

endmodule

// File: tb/tb_ika2151_dac_serializer.sv
module tb_ika2151_dac_serializer;

  logic clk = 1'b0;
  logic rst;

  ika2151_dac_if bus ();

  ika2151_dac_serializer dut (
    .i_EMUCLK (clk),
    .i_MRST   (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: the held pair and the expected-word scoreboard.
  logic signed [15:0] m_hold_l;
  logic signed [15:0] m_hold_r;
  logic [15:0]        exp_q[$];

  // Encoding computed straight from the arithmetic definition.
  function automatic logic [15:0] ref_word(input logic signed [15:0] s);
    int sv, e, q, found;
    logic [9:0] m;
    logic [2:0] e3;
    sv = s;
    found = 0;
    e = 7;
    for (int k = 1; k <= 7; k++) begin
      q = sv >>> (k - 1);
      if (found == 0 && q >= -512 && q <= 511) begin
        e = k;
        found = 1;
      end
    end
    q = sv >>> (e - 1);
`ifdef IKA2151_DAC_ROUND_EN
    if (e >= 2) q = q + ((sv >>> (e - 2)) & 1);
    if (q == 512) begin
      if (e == 7) q = 511;
      else begin
        e = e + 1;
        q = 256;
      end
    end
`endif
    m  = q[9:0];
    e3 = e[2:0];
    return {e3, m ^ 10'h200, 3'b000};
  endfunction

  function automatic logic signed [15:0] rnd_sample();
    logic signed [15:0] v;
    v = 16'($urandom);
    return v >>> $urandom_range(0, 15);
  endfunction

  // One enabled tick, preceded by 0..2 disabled cycles carrying junk inputs.
  task automatic tick(input logic cyc, input logic ld,
                      input logic [15:0] l, input logic [15:0] r);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      bus.i_phi1_NCEN_n = 1'b1;
      bus.i_CYCLE_31    = 1'($urandom_range(0, 1));
      bus.i_ACC_LD      = 1'($urandom_range(0, 1));
      bus.i_ACC_L       = 16'($urandom);
      bus.i_ACC_R       = 16'($urandom);
      @(posedge clk); #1;
    end
    bus.i_phi1_NCEN_n = 1'b0;
    bus.i_CYCLE_31    = cyc;
    bus.i_ACC_LD      = ld;
    bus.i_ACC_L       = l;
    bus.i_ACC_R       = r;
    @(posedge clk); #1;
    bus.i_phi1_NCEN_n = 1'b1;
    bus.i_CYCLE_31    = 1'b0;
    bus.i_ACC_LD      = 1'b0;
  endtask

  // A whole frame: load tick (slot 0) plus 31 shift ticks. Optionally a late
  // strobe at slot late_idx. Collects the serialized words and strobe stats
  // and pushes the model's expected words onto exp_q (left then right).
  task automatic do_frame(input logic ld, input logic signed [15:0] l, r,
                          input int late_idx, input logic signed [15:0] ll, lr,
                          output logic [15:0] obs_l, output logic [15:0] obs_r,
                          output int sh1_cnt, output int sh2_cnt, output int sh_bad);
    logic signed [15:0] src_l, src_r;
    src_l = ld ? l : m_hold_l;
    src_r = ld ? r : m_hold_r;
    if (ld) begin
      m_hold_l = l;
      m_hold_r = r;
    end
    exp_q.push_back(ref_word(src_l));
    exp_q.push_back(ref_word(src_r));
    sh1_cnt = 0;
    sh2_cnt = 0;
    sh_bad  = 0;
    obs_l   = '0;
    obs_r   = '0;
    for (int k = 0; k < 32; k++) begin
      if (k == 0) tick(1'b1, ld, l, r);
      else if (k == late_idx) begin
        tick(1'b0, 1'b1, ll, lr);
        m_hold_l = ll;
        m_hold_r = lr;
      end else tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      if (k < 16) obs_l[k] = bus.o_SO;
      else obs_r[k-16] = bus.o_SO;
      if (bus.o_SH1 === 1'b1) sh1_cnt++;
      if (bus.o_SH2 === 1'b1) sh2_cnt++;
      if (bus.o_SH1 !== (k < 16) || bus.o_SH2 !== (k >= 16)) sh_bad++;
    end
  endtask

  logic [15:0] obs_l, obs_r, exp_l, exp_r;
  int          sh1_cnt, sh2_cnt, sh_bad;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_hold_l = '0;
    m_hold_r = '0;
    tests_run++;
    if (bus.o_SO !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_so got=%b exp=0", bus.o_SO);
    end
    tests_run++;
    if (bus.o_SH1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_sh1 got=%b exp=0", bus.o_SH1);
    end
    tests_run++;
    if (bus.o_SH2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_sh2 got=%b exp=0", bus.o_SH2);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      tests_run++;
      if ({bus.o_SO, bus.o_SH1, bus.o_SH2} !== 3'b000) begin
        tests_failed++;
        $display("FAIL preframe_outputs tick=%0d got=%b exp=000", i,
                 {bus.o_SO, bus.o_SH1, bus.o_SH2});
      end
    end
    do_frame(1'b0, 16'sd0, 16'sd0, -1, 16'sd0, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    tests_run++;
    if (obs_l !== 16'h3000) begin
      tests_failed++;
      $display("FAIL first_frame_left got=%h exp=3000", obs_l);
    end
    tests_run++;
    if (obs_r !== 16'h3000) begin
      tests_failed++;
      $display("FAIL first_frame_right got=%h exp=3000", obs_r);
    end
  endtask

  task automatic test_bypass();
    do_frame(1'b1, 16'sd511, 16'sd512, -1, 16'sd0, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    tests_run++;
    if (obs_l !== 16'h3FF8) begin
      tests_failed++;
      $display("FAIL bypass_left got=%h exp=3ff8", obs_l);
    end
    tests_run++;
    if (obs_r !== 16'h5800) begin
      tests_failed++;
      $display("FAIL bypass_right got=%h exp=5800", obs_r);
    end
    // No new strobe: the held pair repeats.
    do_frame(1'b0, 16'sd0, 16'sd0, -1, 16'sd0, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    tests_run++;
    if ({obs_l, obs_r} !== {16'h3FF8, 16'h5800}) begin
      tests_failed++;
      $display("FAIL repeat_hold got=%h_%h exp=3ff8_5800", obs_l, obs_r);
    end
  endtask

  task automatic test_extremes();
    do_frame(1'b1, -16'sd32768, 16'sd32767, -1, 16'sd0, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    tests_run++;
    if (obs_l !== 16'hE000) begin
      tests_failed++;
      $display("FAIL extreme_left got=%h exp=e000", obs_l);
    end
    tests_run++;
    if (obs_r !== 16'hFFF8) begin
      tests_failed++;
      $display("FAIL extreme_right got=%h exp=fff8", obs_r);
    end
    tests_run++;
    if (sh1_cnt !== 16) begin
      tests_failed++;
      $display("FAIL sh1_width got=%0d exp=16", sh1_cnt);
    end
    tests_run++;
    if (sh2_cnt !== 16) begin
      tests_failed++;
      $display("FAIL sh2_width got=%0d exp=16", sh2_cnt);
    end
    tests_run++;
    if (sh_bad !== 0) begin
      tests_failed++;
      $display("FAIL sh_pattern bad_slots=%0d exp=0", sh_bad);
    end
  endtask

  task automatic test_late_load();
    do_frame(1'b1, 16'sd5, -16'sd7, -1, 16'sd0, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    // Strobe one tick after the frame mark: this frame still carries 5 / -7.
    do_frame(1'b0, 16'sd0, 16'sd0, 1, 16'sd100, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    tests_run++;
    if ({obs_l, obs_r} !== {exp_l, exp_r}) begin
      tests_failed++;
      $display("FAIL late_current_frame got=%h_%h exp=%h_%h", obs_l, obs_r, exp_l, exp_r);
    end
    do_frame(1'b0, 16'sd0, 16'sd0, -1, 16'sd0, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    // 100 -> e=1, mantissa field 0x264 -> {001, 10_0110_0100, 000}
    tests_run++;
    if (obs_l !== 16'h3320) begin
      tests_failed++;
      $display("FAIL late_next_frame_left got=%h exp=3320", obs_l);
    end
    tests_run++;
    if (obs_r !== 16'h3000) begin
      tests_failed++;
      $display("FAIL late_next_frame_right got=%h exp=3000", obs_r);
    end
  endtask

  task automatic test_rounding();
`ifdef IKA2151_DAC_ROUND_EN
    do_frame(1'b1, 16'sd513, 16'sd1023, -1, 16'sd0, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    tests_run++;
    if (obs_l !== 16'h5808) begin
      tests_failed++;
      $display("FAIL round_513 got=%h exp=5808", obs_l);
    end
    tests_run++;
    if (obs_r !== 16'h7800) begin
      tests_failed++;
      $display("FAIL round_1023 got=%h exp=7800", obs_r);
    end
`else
    do_frame(1'b1, 16'sd1023, 16'sd513, -1, 16'sd0, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    tests_run++;
    if (obs_l !== 16'h5FF8) begin
      tests_failed++;
      $display("FAIL trunc_1023 got=%h exp=5ff8", obs_l);
    end
    tests_run++;
    if (obs_r !== 16'h5800) begin
      tests_failed++;
      $display("FAIL trunc_513 got=%h exp=5800", obs_r);
    end
`endif
  endtask

  task automatic test_random();
    logic               ld;
    logic signed [15:0] l, r, ll, lr;
    int                 late;
    for (int f = 0; f < 24; f++) begin
      ld   = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      l    = rnd_sample();
      r    = rnd_sample();
      ll   = rnd_sample();
      lr   = rnd_sample();
      late = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : -1;
      do_frame(ld, l, r, late, ll, lr, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
      exp_l = exp_q.pop_front();
      exp_r = exp_q.pop_front();
      tests_run++;
      if ({obs_l, obs_r} !== {exp_l, exp_r}) begin
        tests_failed++;
        $display("FAIL random_frame f=%0d got=%h_%h exp=%h_%h", f, obs_l, obs_r, exp_l, exp_r);
      end
      tests_run++;
      if (sh_bad !== 0) begin
        tests_failed++;
        $display("FAIL random_strobes f=%0d bad_slots=%0d exp=0", f, sh_bad);
      end
    end
  endtask

  task automatic test_midframe_reset();
    tick(1'b1, 1'b1, 16'sh1234, -16'sd300);
    for (int k = 1; k <= 9; k++) tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    tests_run++;
    if (bus.o_SH1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL slot9_sh1 got=%b exp=1", bus.o_SH1);
    end
    // Reset with the clock enable inactive: must still clear on this edge.
    bus.i_phi1_NCEN_n = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hold_l = '0;
    m_hold_r = '0;
    tests_run++;
    if ({bus.o_SO, bus.o_SH1, bus.o_SH2} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midframe_reset got=%b exp=000", {bus.o_SO, bus.o_SH1, bus.o_SH2});
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      tests_run++;
      if ({bus.o_SO, bus.o_SH1, bus.o_SH2} !== 3'b000) begin
        tests_failed++;
        $display("FAIL post_reset_idle tick=%0d got=%b exp=000", i,
                 {bus.o_SO, bus.o_SH1, bus.o_SH2});
      end
    end
    do_frame(1'b0, 16'sd0, 16'sd0, -1, 16'sd0, 16'sd0, obs_l, obs_r, sh1_cnt, sh2_cnt, sh_bad);
    exp_l = exp_q.pop_front();
    exp_r = exp_q.pop_front();
    tests_run++;
    if ({obs_l, obs_r} !== {16'h3000, 16'h3000}) begin
      tests_failed++;
      $display("FAIL post_reset_frame got=%h_%h exp=3000_3000", obs_l, obs_r);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_phi1_NCEN_n = 1'b1;
    bus.i_CYCLE_31    = 1'b0;
    bus.i_ACC_LD      = 1'b0;
    bus.i_ACC_L       = '0;
    bus.i_ACC_R       = '0;
    m_hold_l          = '0;
    m_hold_r          = '0;
    test_reset();
    test_bypass();
    test_extremes();
    test_late_load();
    test_rounding();
    test_random();
    test_midframe_reset();
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
